// File: rtl/boxhead_input_pkg.sv
// Shared input-decoding types and default keycodes for the player-control path.
// dir_t   : facing / movement direction (UP=0, DOWN=1, LEFT=2, RIGHT=3)
// state_t : keycode_action_decoder FSM states
// DEF_KEY_*: HID usage codes for W/S/A/D/Space
package boxhead_input_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_FIRE = 2'd2
    } state_t;

    localparam logic [7:0] DEF_KEY_UP    = 8'h1A;
    localparam logic [7:0] DEF_KEY_DOWN  = 8'h16;
    localparam logic [7:0] DEF_KEY_LEFT  = 8'h04;
    localparam logic [7:0] DEF_KEY_RIGHT = 8'h07;
    localparam logic [7:0] DEF_KEY_FIRE  = 8'h2C;

endpackage

// File: rtl/keycode_stabilizer.sv
// Stability filter for the raw keycode written by software.
// A code is accepted into stable_code only after it has been sampled
// STABLE_CYCLES+1 times in a row; key_event strobes for one cycle when the
// accepted value is new and nonzero.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   keycode      : raw keycode (WIDTH bits)
//   stable_code  : debounced keycode
//   key_event    : one-cycle strobe on a new nonzero stable_code
module keycode_stabilizer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] keycode,
    output logic [WIDTH-1:0] stable_code,
    output logic             key_event
);

    localparam int             CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_ACCEPT = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] keycode_q;
    logic [CW-1:0]    count;
    logic             same;
    logic             accept;

    assign same   = (keycode == keycode_q);
    assign accept = same && (count == CNT_ACCEPT);

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keycode_q   <= '0;
            count       <= '0;
            stable_code <= '0;
            key_event   <= 1'b0;
        end else begin
            keycode_q <= keycode;
            if (!same)
                count <= '0;
            else if (count != CNT_MAX)
                count <= count + CW'(1);   // saturates, so acceptance happens once per run
            if (accept)
                stable_code <= keycode_q;
            key_event <= accept && (keycode_q != stable_code) && (keycode_q != '0);
        end
    end

endmodule

// File: rtl/keycode_action_decoder.sv
// Turns the software-written keycode into player-control intents:
// frame-aligned movement steps, a facing direction and rate-limited fire pulses.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   keycode      : raw keycode from the PIO
//   frame_tick   : one-cycle pulse per video frame
//   stable_code  : debounced keycode
//   key_event    : one-cycle strobe on a new nonzero stable_code
//   moving       : a direction key is held
//   facing       : UP=0, DOWN=1, LEFT=2, RIGHT=3
//   move_valid   : one-cycle movement step, at most one per frame
//   move_dir     : direction of the step (facing at the tick)
//   fire_pulse   : one-cycle fire strobe
module keycode_action_decoder
    import boxhead_input_pkg::*;
#(
    parameter logic [7:0] KEY_UP             = DEF_KEY_UP,
    parameter logic [7:0] KEY_DOWN           = DEF_KEY_DOWN,
    parameter logic [7:0] KEY_LEFT           = DEF_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT          = DEF_KEY_RIGHT,
    parameter logic [7:0] KEY_FIRE           = DEF_KEY_FIRE,
    parameter int         STABLE_CYCLES      = 4,
    parameter int         FIRE_REPEAT_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic [7:0] stable_code,
    output logic       key_event,
    output logic       moving,
    output logic [1:0] facing,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       fire_pulse
);

    localparam int            FRW         = (FIRE_REPEAT_FRAMES > 1) ? $clog2(FIRE_REPEAT_FRAMES) : 1;
    localparam logic [FRW-1:0] REPEAT_LAST = FRW'(FIRE_REPEAT_FRAMES - 1);

    state_t         state, next_state;
    dir_t           code_dir;
    logic           is_dir;
    logic           fire_entry;
    logic           fire_first;     // high during the first cycle spent in FIRE
    logic           repeat_tick;
    logic           repeat_due;
    logic [FRW-1:0] fire_count;

    keycode_stabilizer #(
        .WIDTH         (8),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stabilizer (
        .clk         (clk),
        .reset       (reset),
        .keycode     (keycode),
        .stable_code (stable_code),
        .key_event   (key_event)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        is_dir   = 1'b1;
        code_dir = DIR_DOWN;
        case (stable_code)
            KEY_UP:    code_dir = DIR_UP;
            KEY_DOWN:  code_dir = DIR_DOWN;
            KEY_LEFT:  code_dir = DIR_LEFT;
            KEY_RIGHT: code_dir = DIR_RIGHT;
            default:   is_dir   = 1'b0;
        endcase
    end

    // Transitions depend only on the held code, whatever the current state.
    always_comb begin
        next_state = ST_IDLE;
        if (is_dir)
            next_state = ST_MOVE;
        else if (stable_code == KEY_FIRE)
            next_state = ST_FIRE;

        fire_entry  = (next_state == ST_FIRE) && (state != ST_FIRE);
        // A tick in the entry cycle does not count toward the repeat interval.
        repeat_tick = (state == ST_FIRE) && (next_state == ST_FIRE) && frame_tick && !fire_first;
        repeat_due  = repeat_tick && (fire_count == REPEAT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            facing     <= DIR_DOWN;
            moving     <= 1'b0;
            move_valid <= 1'b0;
            move_dir   <= DIR_UP;
            fire_pulse <= 1'b0;
            fire_first <= 1'b0;
            fire_count <= '0;
        end else begin
            state  <= next_state;
            moving <= (next_state == ST_MOVE);
            if (next_state == ST_MOVE)
                facing <= code_dir;

            // Judged on the registered state, so a tick coinciding with a
            // code change still steps in the old direction.
            move_valid <= frame_tick && (state == ST_MOVE);
            move_dir   <= facing;

            fire_pulse <= fire_entry || repeat_due;
            fire_first <= fire_entry;
            if (next_state != ST_FIRE || fire_entry)
                fire_count <= '0;
            else if (repeat_tick)
                fire_count <= repeat_due ? '0 : fire_count + FRW'(1);
        end
    end

endmodule
